uart_rx: RTL and testbench

Serial UART receiver. It is the downstream partner of the UART transmitter: it consumes the TX_OUT serial line and rebuilds the parallel byte. The line is oversampled by a configurable prescale, each bit is decided by a 3-sample majority vote, and parity and stop bits are checked. Frame format matches the transmitter: 1 start (0), DATA_WD data bits LSB first, optional parity, 1 stop (1).

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Bundle of the serial line, the frame configuration and the received-byte outputs of uart_rx.
// The testbench or the parent block drives through master; the receiver uses slave.
interface uart_rx_if #(
  parameter int DATA_WD  = 8,
  parameter int PRESC_WD = 6
);
  logic                RX_IN;
  logic [PRESC_WD-1:0] prescale;
  logic                parity_enable;
  logic                parity_type;
  logic [DATA_WD-1:0]  P_DATA;
  logic                data_valid;
  logic                parity_error;
  logic                stop_error;

  modport master (
    output RX_IN, prescale, parity_enable, parity_type,
    input  P_DATA, data_valid, parity_error, stop_error
  );

  modport slave (
    input  RX_IN, prescale, parity_enable, parity_type,
    output P_DATA, data_valid, parity_error, stop_error
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 3-sample majority vote per bit, optional parity, stop check.
// Results are single-cycle pulses one clock after the stop-bit vote.
module uart_rx #(
  parameter int DATA_WD  = 8,
  parameter int PRESC_WD = 6
) (
  input  logic     CLK,
  input  logic     RST,
  uart_rx_if.slave bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam int BC_WD = $clog2(DATA_WD + 1);

  logic [2:0]          r_state;
  logic [PRESC_WD-1:0] r_p;
  logic [PRESC_WD-1:0] r_edge_cnt;
  logic [BC_WD-1:0]    r_bit_cnt;
  logic                r_par_en;
  logic                r_par_type;
  logic                r_par_err;
  logic [2:0]          r_smp;
  logic [DATA_WD-1:0]  r_shift;
  logic [DATA_WD-1:0]  r_p_data;
  logic                r_dv;
  logic                r_pe;
  logic                r_se;

  logic [PRESC_WD-1:0] w_p;
  logic [PRESC_WD-1:0] w_half;
  logic                w_smp0;
  logic                w_smp1;
  logic                w_smp2;
  logic                w_vote_pt;
  logic                w_wrap;
  logic                w_vote;
  logic                w_exp_par;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Prescale decode: only 16 and 32 are honoured, everything else means 8.
  always_comb begin
    case (bus.prescale)
      PRESC_WD'(16): w_p = PRESC_WD'(16);
      PRESC_WD'(32): w_p = PRESC_WD'(32);
      default:       w_p = PRESC_WD'(8);
    endcase
  end

  assign w_half    = r_p >> 1;
  assign w_smp0    = (r_edge_cnt == w_half - PRESC_WD'(1));
  assign w_smp1    = (r_edge_cnt == w_half);
  assign w_smp2    = (r_edge_cnt == w_half + PRESC_WD'(1));
  assign w_vote_pt = (r_edge_cnt == w_half + PRESC_WD'(2));
  assign w_wrap    = (r_edge_cnt == r_p - PRESC_WD'(1));
  assign w_vote    = majority3(r_smp);
  assign w_exp_par = (^r_shift) ^ r_par_type;

  // Capture the three mid-bit samples of the line.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_smp <= 3'b111;
    end else if (r_state != S_IDLE) begin
      if (w_smp0) r_smp[0] <= bus.RX_IN;
      if (w_smp1) r_smp[1] <= bus.RX_IN;
      if (w_smp2) r_smp[2] <= bus.RX_IN;
    end
  end

  // Frame FSM, bit timing counters, data shift register and parity check.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_p        <= PRESC_WD'(8);
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
      r_par_err  <= 1'b0;
      r_shift    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_edge_cnt <= '0;
          // The detecting cycle itself is edge 0, so the counter continues from 1.
          if (!bus.RX_IN) begin
            r_state    <= S_START;
            r_edge_cnt <= PRESC_WD'(1);
            r_p        <= w_p;
            r_par_en   <= bus.parity_enable;
            r_par_type <= bus.parity_type;
            r_par_err  <= 1'b0;
          end
        end
        S_START: begin
          if (w_vote_pt && w_vote) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
          end else if (w_wrap) begin
            r_state    <= S_DATA;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
          end else begin
            r_edge_cnt <= r_edge_cnt + PRESC_WD'(1);
          end
        end
        S_DATA: begin
          r_edge_cnt <= w_wrap ? '0 : r_edge_cnt + PRESC_WD'(1);
          if (w_vote_pt) begin
            r_shift   <= {w_vote, r_shift[DATA_WD-1:1]};
            r_bit_cnt <= r_bit_cnt + BC_WD'(1);
          end
          if (w_wrap && (r_bit_cnt == BC_WD'(DATA_WD))) begin
            r_state <= r_par_en ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          r_edge_cnt <= w_wrap ? '0 : r_edge_cnt + PRESC_WD'(1);
          if (w_vote_pt) r_par_err <= (w_vote != w_exp_par);
          if (w_wrap) r_state <= S_STOP;
        end
        S_STOP: begin
          // Leave mid-stop-bit so a back-to-back start edge is not missed.
          if (w_vote_pt) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
          end else begin
            r_edge_cnt <= r_edge_cnt + PRESC_WD'(1);
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_edge_cnt <= '0;
        end
      endcase
    end
  end

  // Frame result pulses and the held output byte.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_p_data <= '0;
      r_dv     <= 1'b0;
      r_pe     <= 1'b0;
      r_se     <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      r_pe <= 1'b0;
      r_se <= 1'b0;
      if ((r_state == S_STOP) && w_vote_pt) begin
        r_dv <= w_vote & ~r_par_err;
        r_pe <= r_par_err;
        r_se <= ~w_vote;
        if (w_vote && !r_par_err) r_p_data <= r_shift;
      end
    end
  end

  assign bus.P_DATA       = r_p_data;
  assign bus.data_valid   = r_dv;
  assign bus.parity_error = r_pe;
  assign bus.stop_error   = r_se;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-written corner sequences,
// with expected pulses queued at drive time and compared when the receiver pulses.
module tb_uart_rx;
  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  uart_rx_if #(.DATA_WD(8), .PRESC_WD(6)) bus ();

  uart_rx #(.DATA_WD(8), .PRESC_WD(6)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic       v;
    logic       pe;
    logic       se;
    logic [7:0] d;
  } exp_t;

  typedef struct packed {
    logic [5:0] presc;
    logic       par_en;
    logic       par_type;
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic       ev;
    logic       epe;
    logic       ese;
  } vec_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         checks   = 0;
  int         failures = 0;
  int         pulses   = 0;
  int         pulses_before;
  logic [7:0] model_pdata = 8'h00;

  vec_t vecs [9] = '{
    '{6'd8,  1'b0, 1'b0, 8'hA3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
    '{6'd16, 1'b1, 1'b0, 8'hB4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
    '{6'd16, 1'b1, 1'b0, 8'hB4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0},
    '{6'd32, 1'b1, 1'b1, 8'hD2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
    '{6'd32, 1'b1, 1'b1, 8'hD2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
    '{6'd16, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1},
    '{6'd5,  1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
    '{6'd8,  1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
    '{6'd8,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Pop one expectation per observed result pulse and compare flags and byte.
  always @(negedge CLK) begin
    if (RST === 1'b1 && (bus.data_valid || bus.parity_error || bus.stop_error)) begin
      pulses++;
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, bus.data_valid, bus.parity_error, bus.stop_error}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("flags", {29'd0, bus.data_valid, bus.parity_error, bus.stop_error},
              {29'd0, mon_e.v, mon_e.pe, mon_e.se});
        check("p_data", {24'd0, bus.P_DATA}, {24'd0, mon_e.d});
      end
    end
  end

  function automatic int period(input logic [5:0] presc);
    return (presc == 6'd16) ? 16 : ((presc == 6'd32) ? 32 : 8);
  endfunction

  task automatic push_exp(input logic v, input logic pe, input logic se, input logic [7:0] d);
    if (v) model_pdata = d;
    sb_q.push_back('{v: v, pe: pe, se: se, d: model_pdata});
  endtask

  task automatic send_bit(input logic b, input int p, input logic glitch);
    for (int k = 0; k < p; k++) begin
      bus.RX_IN = (glitch && k == p / 2) ? ~b : b;
      @(negedge CLK);
    end
  endtask

  task automatic send_frame(input int p, input logic [7:0] d, input logic pe, input logic pbit,
                            input logic stop, input logic glitch, input logic chg);
    send_bit(1'b0, p, glitch);
    if (chg) begin
      bus.prescale      = 6'd32;
      bus.parity_enable = ~bus.parity_enable;
    end
    for (int i = 0; i < 8; i++) send_bit(d[i], p, glitch);
    if (pe) send_bit(pbit, p, glitch);
    send_bit(stop, p, glitch);
    bus.RX_IN = 1'b1;
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge CLK);
    check(name, sb_q.size(), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    RST               = 1'b0;
    bus.RX_IN         = 1'b1;
    bus.prescale      = 6'd8;
    bus.parity_enable = 1'b0;
    bus.parity_type   = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_outputs", {21'd0, bus.P_DATA, bus.data_valid, bus.parity_error, bus.stop_error}, 32'd0);
    RST = 1'b1;
    repeat (4) @(negedge CLK);

    for (int i = 0; i < 9; i++) begin
      bus.prescale      = vecs[i].presc;
      bus.parity_enable = vecs[i].par_en;
      bus.parity_type   = vecs[i].par_type;
      push_exp(vecs[i].ev, vecs[i].epe, vecs[i].ese, vecs[i].data);
      send_frame(period(vecs[i].presc), vecs[i].data, vecs[i].par_en, vecs[i].pbit,
                 vecs[i].stop, 1'b0, 1'b0);
      drain("vec_drained");
      repeat (4) @(negedge CLK);
    end

    // Start glitch: two low clocks must not produce any pulse, then a good frame.
    bus.prescale      = 6'd8;
    bus.parity_enable = 1'b0;
    pulses_before     = pulses;
    bus.RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    bus.RX_IN = 1'b1;
    repeat (24) @(negedge CLK);
    check("glitch_no_pulse", pulses, pulses_before);
    push_exp(1'b1, 1'b0, 1'b0, 8'h5A);
    send_frame(8, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drain("glitch_frame_drained");

    // Back-to-back frames with one corrupted sample per bit.
    push_exp(1'b1, 1'b0, 1'b0, 8'h01);
    push_exp(1'b1, 1'b0, 1'b0, 8'hFF);
    send_frame(8, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drain("b2b_drained");
    repeat (4) @(negedge CLK);

    // Config change after the start bit must not affect the frame in flight.
    bus.prescale      = 6'd16;
    bus.parity_enable = 1'b0;
    push_exp(1'b1, 1'b0, 1'b0, 8'h6E);
    send_frame(16, 8'h6E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drain("cfg_latch_drained");
    repeat (4) @(negedge CLK);

    // Reset during data bit 4 aborts the frame and clears the byte.
    bus.prescale      = 6'd8;
    bus.parity_enable = 1'b0;
    pulses_before     = pulses;
    send_bit(1'b0, 8, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 8, 1'b0);
    bus.RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    bus.RX_IN = 1'b1;
    check("reset_mid_frame_pdata", {24'd0, bus.P_DATA}, 32'd0);
    RST = 1'b1;
    model_pdata = 8'h00;
    repeat (20) @(negedge CLK);
    check("reset_mid_frame_no_pulse", pulses, pulses_before);
    check("reset_pdata_held", {24'd0, bus.P_DATA}, 32'd0);
    push_exp(1'b1, 1'b0, 1'b0, 8'h3C);
    send_frame(8, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drain("post_reset_drained");
    check("post_reset_pulse_count", pulses, pulses_before + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
